rv_brick_ctrl: RTL and testbench
================================

RV_BRICK_CTRL -- requirements
Module: rv_brick_ctrl

Interface
REQ-001 SHALL have parameter ITAG_WIDTH, default 7, meaning width of the instruction tag carried with a brick.
REQ-002 SHALL have parameter PERF_WIDTH, default 16, meaning width of the stall-cycle counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port issue_v, input, 1, an instruction issues from the reservation station this cycle.
REQ-006 SHALL have port issue_is_brick, input, 1, issuing instruction is a brick (from the RV instruction decoder).
REQ-007 SHALL have port issue_brick_cycles, input, [0:2], brick length code from the decoder, with bit 0 the MSB.
REQ-008 SHALL have port issue_itag, input, [0:ITAG_WIDTH-1], tag of the issuing instruction.
REQ-009 SHALL have port cp_flush, input, 1, completion flush that cancels any active brick.
REQ-010 SHALL have port perf_clr, input, 1, clears the stall-cycle counter.
REQ-011 SHALL have port rv_brick_stall, output, 1, blocks all issue while high.
REQ-012 SHALL have port brick_itag, output, [0:ITAG_WIDTH-1], tag of the active brick.
REQ-013 SHALL have port rv_brick_perf_cnt, output, [0:PERF_WIDTH-1], stall-cycle count.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and BRICK, plus a 3-bit down-counter cnt.
REQ-015 In IDLE: issue_v & issue_is_brick & ~cp_flush SHALL load cnt <= issue_brick_cycles and brick_itag <= issue_itag, and the next state SHALL be BRICK.
REQ-016 In IDLE, a non-brick issue (issue_v & ~issue_is_brick) SHALL change no state.
REQ-017 In BRICK: if cnt == 0 the next state SHALL be IDLE; otherwise cnt <= cnt - 1 and the FSM SHALL stay in BRICK.
REQ-018 rv_brick_stall SHALL be registered and equal (state == BRICK).
REQ-019 Timing: a brick issued in cycle T with code C SHALL hold the stall high in cycles T+1 through T+C+1, i.e. C+1 cycles; the range is 1..8 cycles.
REQ-020 brick_itag SHALL hold the captured tag while in BRICK and SHALL be zero in IDLE.
REQ-021 cp_flush in BRICK SHALL force IDLE next cycle and zero cnt, regardless of cnt.
REQ-022 cp_flush concurrent with a brick issue in IDLE SHALL take priority: no brick is loaded.
REQ-023 issue_v while rv_brick_stall is high is a protocol violation; the block SHALL ignore it and keep the current countdown.
REQ-024 The earliest next brick issue is cycle T+C+2, the first IDLE cycle; no bubble beyond the stall window.

Reset
REQ-025 rst SHALL force state IDLE, cnt 0, rv_brick_stall 0, brick_itag 0 and rv_brick_perf_cnt 0 at the next edge.
REQ-026 rst asserted mid-brick SHALL abort the brick, with stall low in the cycle after reset.
REQ-027 rst SHALL take priority over cp_flush, issue and perf_clr.

Configuration
REQ-028 Macro RV_BRICK_PERF_EN defined: rv_brick_perf_cnt SHALL increment by 1 for each cycle rv_brick_stall is high, saturate at all-ones, and clear on perf_clr. If perf_clr coincides with a stall cycle, the counter SHALL be 0 next cycle.
REQ-029 Macro RV_BRICK_PERF_EN undefined: rv_brick_perf_cnt SHALL be constant zero with no counter flops, and perf_clr SHALL be unused.

Verification
REQ-030 Brick with code 3'b010 and itag 0x15 at T -> stall high T+1..T+3, brick_itag = 0x15 during those cycles, low/0 at T+4.
REQ-031 Brick with code 3'b000 at T, second brick with code 3'b001 at T+2 -> stall high T+1, then T+3..T+4, and never low-then-missed.
REQ-032 Brick with code 3'b111 at T, cp_flush at T+3 -> stall high T+1..T+3, low from T+4.
REQ-033 Brick issue together with cp_flush in IDLE -> stall never rises; non-brick issue alone -> stall stays 0.
REQ-034 Brick with code 3'b011, rst at T+2 -> stall high T+1..T+2, and from T+3 all outputs 0.
REQ-035 With RV_BRICK_PERF_EN and PERF_WIDTH 4: 20 stall cycles -> count saturates at 4'hF; perf_clr -> 0 next cycle. Without the macro -> count always 0.

Source files
------------

// File: rtl/rv_brick_ctrl.sv
// rv_brick_ctrl: RV brick-instruction issue controller.
// A "brick" issue blocks all further issue for (code+1) cycles.
// During that window the block outputs the brick's tag and counts stall cycles.
// Optional feature macro: RV_BRICK_PERF_EN.
// When RV_BRICK_PERF_EN is defined, a saturating stall-cycle counter is built.
// When it is undefined, rv_brick_perf_cnt is tied to zero.
module rv_brick_ctrl #(
  parameter int unsigned ITAG_WIDTH = 7,
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_v,
  input  logic                  issue_is_brick,
  input  logic [0:2]            issue_brick_cycles,
  input  logic [0:ITAG_WIDTH-1] issue_itag,
  input  logic                  cp_flush,
  input  logic                  perf_clr,
  output logic                  rv_brick_stall,
  output logic [0:ITAG_WIDTH-1] brick_itag,
  output logic [0:PERF_WIDTH-1] rv_brick_perf_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    BRICK = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  // Brick FSM with down-counter; stall and tag are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rv_brick_stall <= 1'b0;
      brick_itag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_v && issue_is_brick && !cp_flush) begin
            state          <= BRICK;
            cnt            <= issue_brick_cycles;
            brick_itag     <= issue_itag;
            rv_brick_stall <= 1'b1;
          end
        end
        BRICK: begin
          if (cp_flush || (cnt == 3'd0)) begin
            state          <= IDLE;
            cnt            <= '0;
            brick_itag     <= '0;
            rv_brick_stall <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          brick_itag     <= '0;
          rv_brick_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef RV_BRICK_PERF_EN
  // Saturating count of stall cycles; perf_clr wins over a concurrent increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      rv_brick_perf_cnt <= '0;
    end else if (rv_brick_stall && (rv_brick_perf_cnt != '1)) begin
      rv_brick_perf_cnt <= rv_brick_perf_cnt + 1'b1;
    end
  end
`else
  logic unused_perf_clr;

  // Counter not built: output is a constant zero and perf_clr has no effect.
  always_comb begin
    rv_brick_perf_cnt = '0;
    unused_perf_clr   = perf_clr;
  end
`endif

endmodule

// File: tb/tb_rv_brick_ctrl.sv
// Self-checking bench for rv_brick_ctrl.
// The reference model tracks the number of stall cycles still owed.
// It also keeps a captured tag and a saturating perf count.
module tb_rv_brick_ctrl;

  localparam int unsigned IW = 7;
  localparam int unsigned PW = 4;

  logic          clk;
  logic          rst;
  logic          issue_v;
  logic          issue_is_brick;
  logic [0:2]    issue_brick_cycles;
  logic [0:IW-1] issue_itag;
  logic          cp_flush;
  logic          perf_clr;
  logic          rv_brick_stall;
  logic [0:IW-1] brick_itag;
  logic [0:PW-1] rv_brick_perf_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int       m_left = 0;   // stall cycles still to be shown, including the current one
  bit [6:0] m_tag  = '0;
  int       m_perf = 0;

  rv_brick_ctrl #(.ITAG_WIDTH(IW), .PERF_WIDTH(PW)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_v           (issue_v),
    .issue_is_brick    (issue_is_brick),
    .issue_brick_cycles(issue_brick_cycles),
    .issue_itag        (issue_itag),
    .cp_flush          (cp_flush),
    .perf_clr          (perf_clr),
    .rv_brick_stall    (rv_brick_stall),
    .brick_itag        (brick_itag),
    .rv_brick_perf_cnt (rv_brick_perf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit v, input bit br, input bit [2:0] code, input bit [6:0] tag,
                     input bit fl, input bit clr, input bit r);
    bit old_stall;
    issue_v            = v;
    issue_is_brick     = br;
    issue_brick_cycles = code;
    issue_itag         = tag;
    cp_flush           = fl;
    perf_clr           = clr;
    rst                = r;
    @(posedge clk);
    old_stall = (m_left > 0);
    if (r) begin
      m_left = 0;
      m_perf = 0;
    end else begin
      if (clr) m_perf = 0;
      else if (old_stall && m_perf < (1 << PW) - 1) m_perf = m_perf + 1;
      if (m_left > 0) m_left = fl ? 0 : m_left - 1;
      else if (v && br && !fl) begin
        m_left = int'(code) + 1;
        m_tag  = tag;
      end
    end
    #1;
    chk("stall", {31'd0, rv_brick_stall}, {31'd0, m_left > 0});
    chk("itag", {25'd0, brick_itag}, (m_left > 0) ? {25'd0, m_tag} : 32'd0);
`ifdef RV_BRICK_PERF_EN
    chk("perf", {28'd0, rv_brick_perf_cnt}, m_perf);
`else
    chk("perf", {28'd0, rv_brick_perf_cnt}, 32'd0);
`endif
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    cyc(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_stall", {31'd0, rv_brick_stall}, 32'd0);
    chk("reset_itag", {25'd0, brick_itag}, 32'd0);
    chk("reset_perf", {28'd0, rv_brick_perf_cnt}, 32'd0);
    idle();

    // code 2, tag 0x15: stall for three cycles, then low with tag cleared
    cyc(1'b1, 1'b1, 3'b010, 7'h15, 1'b0, 1'b0, 1'b0);
    chk("b2_t1_stall", {31'd0, rv_brick_stall}, 32'd1);
    chk("b2_t1_itag", {25'd0, brick_itag}, 32'h15);
    idle(); idle();
    chk("b2_t3_stall", {31'd0, rv_brick_stall}, 32'd1);
    idle();
    chk("b2_t4_stall", {31'd0, rv_brick_stall}, 32'd0);
    chk("b2_t4_itag", {25'd0, brick_itag}, 32'd0);

    // code 0, then code 1 issued at the first idle cycle
    cyc(1'b1, 1'b1, 3'b000, 7'h21, 1'b0, 1'b0, 1'b0);
    chk("b0_t1_stall", {31'd0, rv_brick_stall}, 32'd1);
    idle();
    chk("b0_t2_stall", {31'd0, rv_brick_stall}, 32'd0);
    cyc(1'b1, 1'b1, 3'b001, 7'h22, 1'b0, 1'b0, 1'b0);
    chk("b1_t3_stall", {31'd0, rv_brick_stall}, 32'd1);
    idle();
    chk("b1_t4_stall", {31'd0, rv_brick_stall}, 32'd1);
    idle();
    chk("b1_t5_stall", {31'd0, rv_brick_stall}, 32'd0);

    // code 7, flush at T+3; an illegal issue during the stall must be ignored
    cyc(1'b1, 1'b1, 3'b111, 7'h4A, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'b001, 7'h11, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b0, 1'b0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_t4_stall", {31'd0, rv_brick_stall}, 32'd0);
    idle();

    // brick issue with concurrent flush never loads; plain issue never stalls
    cyc(1'b1, 1'b1, 3'b101, 7'h33, 1'b1, 1'b0, 1'b0);
    chk("flush_issue_stall", {31'd0, rv_brick_stall}, 32'd0);
    cyc(1'b1, 1'b0, 3'b101, 7'h34, 1'b0, 1'b0, 1'b0);
    chk("nonbrick_stall", {31'd0, rv_brick_stall}, 32'd0);

    // code 3, reset at T+2 aborts the brick
    cyc(1'b1, 1'b1, 3'b011, 7'h5C, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b1, 1'b1, 3'b001, 7'h01, 1'b1, 1'b1, 1'b1);
    chk("rst_abort_stall", {31'd0, rv_brick_stall}, 32'd0);
    chk("rst_abort_itag", {25'd0, brick_itag}, 32'd0);
    chk("rst_abort_perf", {28'd0, rv_brick_perf_cnt}, 32'd0);

    // three back-to-back code-7 bricks: 24 stall cycles saturate a 4-bit counter
    for (int b = 0; b < 3; b++) begin
      cyc(1'b1, 1'b1, 3'b111, 7'(b + 1), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) idle();
      idle();
    end
`ifdef RV_BRICK_PERF_EN
    chk("perf_sat", {28'd0, rv_brick_perf_cnt}, 32'hF);
`else
    chk("perf_off", {28'd0, rv_brick_perf_cnt}, 32'h0);
`endif
    // clear coinciding with a stall cycle
    cyc(1'b1, 1'b1, 3'b010, 7'h0F, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0);
    chk("perf_clr", {28'd0, rv_brick_perf_cnt}, 32'h0);
    idle(); idle(); idle();

    // randomized traffic, including issues while stalled
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
          7'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
